// File: rtl/snake_motion.sv
// snake_motion: paced snake head mover (buttons/start/GameOver in; head, 20-entry history, move_tick, state out)
module snake_motion #(
  parameter int TICK_DIV = 2500000,
  parameter int STEP = 20,
  parameter int START_X = 320,
  parameter int START_Y = 240,
  parameter int MAX_X = 620,
  parameter int MAX_Y = 460
) (
  input  logic         vga_clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         start,
  input  logic         GameOver,
  output logic [9:0]   snakex,
  output logic [9:0]   snakey,
  output logic [199:0] storex,
  output logic [199:0] storey,
  output logic         move_tick,
  output logic [1:0]   state
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [9:0] S = 10'(STEP);
  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [9:0] SY = 10'(START_Y);
  localparam logic [9:0] MX = 10'(MAX_X);
  localparam logic [9:0] MY = 10'(MAX_Y);
  localparam logic [9:0] XLIM = 10'(MAX_X - STEP);
  localparam logic [9:0] YLIM = 10'(MAX_Y - STEP);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} st_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  st_t st, st_nx;
  dir_t dir, pend, pend_nx, req;
  logic [CW-1:0] cnt, cnt_nx;
  logic have, run, mv, init;
  logic [9:0] nx_x, nx_y;
  assign state = st;
  always_ff @(posedge vga_clk)
    st <= reset ? IDLE : st_nx;
  always_comb begin
    st_nx = st == IDLE ? (start ? RUN : IDLE) : st == RUN ? (GameOver ? DEAD : RUN) : (start ? IDLE : DEAD);
    run = st == RUN && !GameOver;
    init = st == DEAD && start;
    mv = run && cnt == LAST;
    have = btn_up | btn_down | btn_left | btn_right;
    req = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : RIGHT;
    // encoding pairs opposites so they differ only in bit 0
    pend_nx = (run && have && (req ^ dir) != 2'b01) ? req : pend;
    cnt_nx = run ? (cnt == LAST ? '0 : cnt + 1'b1) : st == IDLE ? '0 : cnt;
    nx_x = pend == LEFT ? (snakex < S ? 10'd0 : snakex - S) : pend == RIGHT ? (snakex > XLIM ? MX : snakex + S) : snakex;
    nx_y = pend == UP ? (snakey < S ? 10'd0 : snakey - S) : pend == DOWN ? (snakey > YLIM ? MY : snakey + S) : snakey;
  end
  always_ff @(posedge vga_clk) begin
    if (reset || init) begin
      snakex <= SX;
      snakey <= SY;
      storex <= '0;
      storey <= '0;
      dir <= RIGHT;
      pend <= RIGHT;
      cnt <= '0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= mv;
      pend <= pend_nx;
      cnt <= cnt_nx;
      if (mv) begin
        dir <= pend;
        snakex <= nx_x;
        snakey <= nx_y;
        storex <= {storex[189:0], snakex};
        storey <= {storey[189:0], snakey};
      end
    end
  end
endmodule

// File: tb/tb_snake_motion.sv
// tb_snake_motion: directed table-driven checks of snake_motion with TICK_DIV=4
module tb_snake_motion;
  logic clk = 0, reset = 1, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, start = 0, GameOver = 0;
  logic [9:0] snakex, snakey;
  logic [199:0] storex, storey;
  logic move_tick;
  logic [1:0] state;
  int checks = 0, failures = 0, mx, my;
  always #5 clk = ~clk;
  snake_motion #(.TICK_DIV(4)) dut (
    .vga_clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .start(start), .GameOver(GameOver), .snakex(snakex), .snakey(snakey),
    .storex(storex), .storey(storey), .move_tick(move_tick), .state(state)
  );
  typedef struct {
    logic [3:0] btn;
    logic st, go;
    int n, x, y, s, tk, h0x, h0y, z;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask
  task automatic do_reset;
    reset = 1;
    step(1);
    chk("rst_x", snakex, 320);
    chk("rst_y", snakey, 240);
    chk("rst_state", state, 0);
    chk("rst_tick", move_tick, 0);
    chk("rst_store_zero", int'(storex == '0 && storey == '0), 1);
    reset = 0;
    mx = 320;
    my = 240;
  endtask
  task automatic do_start;
    start = 1;
    step(1);
    start = 0;
    chk("start_state", state, 1);
  endtask
  task automatic run(input logic [3:0] b, input int n, input int dx, input int dy);
    int px, py, ppy;
    ppy = -1;
    set_btn(b);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        chk("y_no_wrap", int'(snakey < 10'd1004), 1);
        chk("tick_pulse", move_tick, int'(c == 3));
      end
      px = mx;
      py = my;
      mx += dx;
      my += dy;
      if (mx < 0) mx = 0;
      if (mx > 620) mx = 620;
      if (my < 0) my = 0;
      if (my > 460) my = 460;
      chk("run_x", snakex, mx);
      chk("run_y", snakey, my);
      chk("hist0_x", storex[9:0], px);
      chk("hist0_y", storey[9:0], py);
      if (ppy >= 0) chk("hist1_y", storey[19:10], ppy);
      ppy = py;
    end
    set_btn(4'b0);
  endtask
  initial begin
    int tk;
    v[0]  = '{4'b0000, 1, 0, 1, 320, 240, 1, 0, 0,   0,   1};
    v[1]  = '{4'b0000, 0, 0, 3, 320, 240, 1, 0, 0,   0,   1};
    v[2]  = '{4'b0000, 0, 0, 1, 340, 240, 1, 1, 320, 240, 0};
    v[3]  = '{4'b0010, 0, 0, 4, 360, 240, 1, 1, 340, 240, 0};
    v[4]  = '{4'b0010, 0, 0, 4, 380, 240, 1, 1, 360, 240, 0};
    v[5]  = '{4'b1010, 0, 0, 4, 380, 220, 1, 1, 380, 240, 0};
    v[6]  = '{4'b0000, 0, 0, 3, 380, 220, 1, 0, 380, 240, 0};
    v[7]  = '{4'b0000, 0, 1, 1, 380, 220, 2, 0, 380, 240, 0};
    v[8]  = '{4'b0000, 0, 1, 2, 380, 220, 2, 0, 380, 240, 0};
    v[9]  = '{4'b0000, 1, 0, 1, 320, 240, 0, 0, 0,   0,   1};
    v[10] = '{4'b0000, 0, 0, 2, 320, 240, 0, 0, 0,   0,   1};
    step(1);
    do_reset;
    tk = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (move_tick) tk++;
    end
    chk("idle_ticks", tk, 0);
    chk("idle_x", snakex, 320);
    chk("idle_state", state, 0);
    for (int i = 0; i < 11; i++) begin
      set_btn(v[i].btn);
      start = v[i].st;
      GameOver = v[i].go;
      step(v[i].n);
      chk($sformatf("v%0d_x", i), snakex, v[i].x);
      chk($sformatf("v%0d_y", i), snakey, v[i].y);
      chk($sformatf("v%0d_state", i), state, v[i].s);
      chk($sformatf("v%0d_tick", i), move_tick, v[i].tk);
      chk($sformatf("v%0d_h0x", i), storex[9:0], v[i].h0x);
      chk($sformatf("v%0d_h0y", i), storey[9:0], v[i].h0y);
      if (v[i].z != 0) chk($sformatf("v%0d_store_zero", i), int'(storex == '0 && storey == '0), 1);
    end
    set_btn(4'b0);
    start = 0;
    GameOver = 0;
    mx = 320;
    my = 240;
    do_start;
    run(4'b1000, 13, 0, -20);
    chk("up_sat", snakey, 0);
    step(1);
    do_reset;
    do_start;
    run(4'b0001, 16, 20, 0);
    chk("right_sat", snakex, 620);
    do_reset;
    do_start;
    run(4'b0100, 12, 0, 20);
    chk("down_sat", snakey, 460);
    do_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
